// File: rtl/pmp_addr_readback_if.sv
// Streaming readback port for PMP address entries.
// The master presents an entry with its index and a last marker; the slave accepts it with ready.
interface pmp_addr_readback_if #(
   parameter int AddrWidth = 34,
   parameter int IdxW      = 2
);
   logic                 out_valid_o;
   logic                 out_ready_i;
   logic [AddrWidth-1:0] out_addr_o;
   logic [IdxW-1:0]      out_idx_o;
   logic                 out_last_o;

   modport master (
      output out_valid_o,
      output out_addr_o,
      output out_idx_o,
      output out_last_o,
      input  out_ready_i
   );

   modport slave (
      input  out_valid_o,
      input  out_addr_o,
      input  out_idx_o,
      input  out_last_o,
      output out_ready_i
   );
endinterface

// File: rtl/pmp_addr_readback.sv
// Snapshots the PMP address CSR array on start and streams each enabled entry,
// in ascending index order, one entry per valid/ready handshake.
module pmp_addr_readback #(
   parameter  int PMPNumRegions = 4,
   parameter  int AddrWidth     = 34,
   localparam int IdxW          = (PMPNumRegions > 1) ? $clog2(PMPNumRegions) : 1,
   localparam int CntW          = $clog2(PMPNumRegions + 1)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   input  logic [PMPNumRegions-1:0] region_en_i,
   input  logic [AddrWidth-1:0]     csr_pmp_addr_i [PMPNumRegions],
   output logic                     busy_o,
   output logic                     done_o,
   output logic [CntW-1:0]          count_o,
   pmp_addr_readback_if.master      out_if
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t                   r_state;
   state_t                   w_next;
   logic [AddrWidth-1:0]     r_snap [PMPNumRegions];
   logic [PMPNumRegions-1:0] r_remaining;
   logic [CntW-1:0]          r_count;

   logic                     w_start_acc;
   logic                     w_valid;
   logic                     w_last;
   logic                     w_hs;
   logic                     w_busy;
   logic                     w_done;
   logic [IdxW-1:0]          w_idx;
   logic [PMPNumRegions-1:0] w_rem_minus1;

   // Lowest enabled entry wins, giving ascending emission order.
   function automatic logic [IdxW-1:0] f_lowest_set(input logic [PMPNumRegions-1:0] m);
      f_lowest_set = '0;
      for (int i = PMPNumRegions - 1; i >= 0; i--) begin
         if (m[i]) f_lowest_set = IdxW'(i);
      end
   endfunction

   assign w_idx        = f_lowest_set(r_remaining);
   assign w_rem_minus1 = r_remaining - PMPNumRegions'(1);
   assign w_start_acc  = (r_state == IDLE) && start_i;
   assign w_hs         = w_valid && out_if.out_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_valid = 1'b0;
      w_last  = 1'b0;
      w_busy  = 1'b0;
      w_done  = 1'b0;
      case (r_state)
         IDLE: begin
            if (start_i) w_next = (|region_en_i) ? STREAM : DONE;
         end
         STREAM: begin
            w_busy  = 1'b1;
            w_valid = |r_remaining;
            w_last  = w_valid && ((r_remaining & w_rem_minus1) == '0);
            if (w_hs && w_last) w_next = DONE;
         end
         DONE: begin
            w_busy = 1'b1;
            w_done = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Snapshot decouples the stream from later CSR writes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < PMPNumRegions; i++) r_snap[i] <= '0;
         r_remaining <= '0;
         r_count     <= '0;
      end else if (w_start_acc) begin
         for (int i = 0; i < PMPNumRegions; i++) r_snap[i] <= csr_pmp_addr_i[i];
         r_remaining <= region_en_i;
         r_count     <= '0;
      end else if (w_hs) begin
         r_remaining <= r_remaining & ~(PMPNumRegions'(1) << w_idx);
         r_count     <= r_count + CntW'(1);
      end
   end

   assign out_if.out_valid_o = w_valid;
   assign out_if.out_last_o  = w_last;
   assign out_if.out_idx_o   = w_valid ? w_idx : '0;
   assign out_if.out_addr_o  = w_valid ? r_snap[w_idx] : '0;
   assign busy_o             = w_busy;
   assign done_o             = w_done;
   assign count_o            = r_count;

endmodule
